// File: rtl/fetch_decode_buffer_pkg.sv
// ============================================================================
// Module   : fetch_decode_buffer_pkg
// Brief    : Shared IF/ID constants for the fetch/decode boundary.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fetch_decode_buffer_pkg;

  localparam int unsigned C_PC_DATA_WIDTH    = 20;
  localparam int unsigned C_INST_DATA_WIDTH  = 32;
  localparam int unsigned C_IFID_ENTRY_WIDTH = C_PC_DATA_WIDTH + C_INST_DATA_WIDTH;

  localparam logic [31:0] C_NOP_INSTRUCTION  = 32'h0000_0000;

  localparam logic [1:0]  C_COUNT_EMPTY      = 2'd0;
  localparam logic [1:0]  C_COUNT_FULL       = 2'd2;

endpackage : fetch_decode_buffer_pkg

`default_nettype wire

// File: rtl/fetch_decode_buffer.sv
// ============================================================================
// Module   : fetch_decode_buffer
// Brief    : Two-entry elastic IF/ID buffer with flush; ready is registered-only.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fetch_decode_buffer
  import fetch_decode_buffer_pkg::*;
#(
  parameter int unsigned                  PC_DATA_WIDTH   = C_PC_DATA_WIDTH,
  parameter int unsigned                  INST_DATA_WIDTH = C_INST_DATA_WIDTH,
  parameter logic [INST_DATA_WIDTH-1:0]   NOP_INSTRUCTION = C_NOP_INSTRUCTION
) (
  input  logic                       clk_in,
  input  logic                       rst_in,
  input  logic                       clk_en_in,
  input  logic                       flush_in,
  input  logic                       fetch_valid_in,
  input  logic [PC_DATA_WIDTH-1:0]   fetch_pc_in,
  input  logic [INST_DATA_WIDTH-1:0] fetch_inst_in,
  output logic                       fetch_ready_out,
  input  logic                       decode_ready_in,
  output logic                       decode_valid_out,
  output logic [PC_DATA_WIDTH-1:0]   decode_pc_out,
  output logic [INST_DATA_WIDTH-1:0] decode_inst_out,
  output logic [1:0]                 occupancy_out
);

  logic [PC_DATA_WIDTH-1:0]   r_pc   [0:1];
  logic [INST_DATA_WIDTH-1:0] r_inst [0:1];
  logic                       r_head;
  logic                       r_tail;
  logic [1:0]                 r_count;

  logic w_push;
  logic w_pop;

  always_comb begin
    fetch_ready_out  = (r_count != C_COUNT_FULL);
    decode_valid_out = (r_count != C_COUNT_EMPTY);
    occupancy_out    = r_count;
    w_push = clk_en_in & fetch_valid_in  & fetch_ready_out  & ~flush_in;
    w_pop  = clk_en_in & decode_valid_out & decode_ready_in & ~flush_in;
  end

  // Decode side reads registered storage only; empty shows a bubble.
  always_comb begin
    decode_pc_out   = '0;
    decode_inst_out = NOP_INSTRUCTION;
    if (decode_valid_out) begin
      decode_pc_out   = r_pc[r_head];
      decode_inst_out = r_inst[r_head];
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_head    <= 1'b0;
      r_tail    <= 1'b0;
      r_count   <= C_COUNT_EMPTY;
      r_pc[0]   <= '0;
      r_pc[1]   <= '0;
      r_inst[0] <= '0;
      r_inst[1] <= '0;
    end else if (clk_en_in) begin
      if (flush_in) begin
        r_head  <= 1'b0;
        r_tail  <= 1'b0;
        r_count <= C_COUNT_EMPTY;
      end else begin
        if (w_push) begin
          r_pc[r_tail]   <= fetch_pc_in;
          r_inst[r_tail] <= fetch_inst_in;
          r_tail         <= ~r_tail;
        end
        if (w_pop) begin
          r_head <= ~r_head;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule : fetch_decode_buffer

`default_nettype wire

// File: tb/tb_fetch_decode_buffer.sv
// ============================================================================
// Module   : tb_fetch_decode_buffer
// Brief    : Directed vector table plus randomized queue-model check.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fetch_decode_buffer;

  localparam int PCW = 20;
  localparam int IW  = 32;
  localparam logic [IW-1:0] NOP = 32'h0000_0000;

  logic           clk_in = 1'b0;
  logic           rst_in;
  logic           clk_en_in;
  logic           flush_in;
  logic           fetch_valid_in;
  logic [PCW-1:0] fetch_pc_in;
  logic [IW-1:0]  fetch_inst_in;
  logic           decode_ready_in;
  logic           fetch_ready_out;
  logic           decode_valid_out;
  logic [PCW-1:0] decode_pc_out;
  logic [IW-1:0]  decode_inst_out;
  logic [1:0]     occupancy_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  fetch_decode_buffer #(
    .PC_DATA_WIDTH   (PCW),
    .INST_DATA_WIDTH (IW),
    .NOP_INSTRUCTION (NOP)
  ) u_dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .clk_en_in        (clk_en_in),
    .flush_in         (flush_in),
    .fetch_valid_in   (fetch_valid_in),
    .fetch_pc_in      (fetch_pc_in),
    .fetch_inst_in    (fetch_inst_in),
    .fetch_ready_out  (fetch_ready_out),
    .decode_ready_in  (decode_ready_in),
    .decode_valid_out (decode_valid_out),
    .decode_pc_out    (decode_pc_out),
    .decode_inst_out  (decode_inst_out),
    .occupancy_out    (occupancy_out)
  );

  typedef struct {
    logic           rst, en, flush, fv, dr;
    logic [PCW-1:0] pc;
    logic [IW-1:0]  inst;
    logic           e_ready, e_valid;
    logic [PCW-1:0] e_pc;
    logic [IW-1:0]  e_inst;
    logic [1:0]     e_occ;
  } vec_t;

  typedef struct {
    logic [PCW-1:0] pc;
    logic [IW-1:0]  inst;
  } ent_t;

  vec_t vecs[$];
  ent_t model[$];

  function automatic vec_t mk(logic rst, logic en, logic flush, logic fv,
                              logic [PCW-1:0] pc, logic [IW-1:0] inst, logic dr,
                              logic e_ready, logic e_valid, logic [PCW-1:0] e_pc,
                              logic [IW-1:0] e_inst, logic [1:0] e_occ);
    vec_t v;
    v.rst = rst; v.en = en; v.flush = flush; v.fv = fv; v.pc = pc; v.inst = inst;
    v.dr = dr; v.e_ready = e_ready; v.e_valid = e_valid; v.e_pc = e_pc;
    v.e_inst = e_inst; v.e_occ = e_occ;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, input logic en, input logic flush, input logic fv,
                       input logic [PCW-1:0] pc, input logic [IW-1:0] inst, input logic dr);
    rst_in = rst; clk_en_in = en; flush_in = flush; fetch_valid_in = fv;
    fetch_pc_in = pc; fetch_inst_in = inst; decode_ready_in = dr;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_all(input string tag, input logic e_ready, input logic e_valid,
                           input logic [PCW-1:0] e_pc, input logic [IW-1:0] e_inst,
                           input logic [1:0] e_occ);
    check({tag, ".ready"}, {31'd0, fetch_ready_out},  {31'd0, e_ready});
    check({tag, ".valid"}, {31'd0, decode_valid_out}, {31'd0, e_valid});
    check({tag, ".pc"},    {12'd0, decode_pc_out},    {12'd0, e_pc});
    check({tag, ".inst"},  decode_inst_out,           e_inst);
    check({tag, ".occ"},   {30'd0, occupancy_out},    {30'd0, e_occ});
  endtask

  // Queue model: each edge applies reset, flush, or pop-then-push on a FIFO of depth 2.
  task automatic model_edge(input logic rst, input logic en, input logic flush,
                            input logic fv, input logic [PCW-1:0] pc,
                            input logic [IW-1:0] inst, input logic dr);
    bit can_push, can_pop;
    ent_t e;
    can_push = fv && (model.size() < 2);
    can_pop  = dr && (model.size() > 0);
    if (rst) model.delete();
    else if (en) begin
      if (flush) model.delete();
      else begin
        if (can_pop) void'(model.pop_front());
        if (can_push) begin
          e.pc = pc; e.inst = inst;
          model.push_back(e);
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    if (model.size() == 0)
      check_all(tag, 1'b1, 1'b0, '0, NOP, 2'd0);
    else
      check_all(tag, model.size() != 2, 1'b1, model[0].pc, model[0].inst, 2'(model.size()));
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);

    //         rst en fl fv pc        inst          dr  rdy val e_pc      e_inst        occ
    vecs.push_back(mk(1, 0, 0, 0, 20'h00000, 32'h0,        0,  1, 0, 20'h00000, NOP,          2'd0));
    vecs.push_back(mk(0, 1, 0, 1, 20'h00000, 32'h20010005, 1,  1, 1, 20'h00000, 32'h20010005, 2'd1));
    vecs.push_back(mk(0, 1, 0, 0, 20'h00000, 32'h0,        1,  1, 0, 20'h00000, NOP,          2'd0));
    vecs.push_back(mk(0, 1, 0, 1, 20'h00000, 32'hA0A0A0A0, 0,  1, 1, 20'h00000, 32'hA0A0A0A0, 2'd1));
    vecs.push_back(mk(0, 1, 0, 1, 20'h00004, 32'hA4A4A4A4, 0,  0, 1, 20'h00000, 32'hA0A0A0A0, 2'd2));
    vecs.push_back(mk(0, 1, 0, 1, 20'h00008, 32'hA8A8A8A8, 0,  0, 1, 20'h00000, 32'hA0A0A0A0, 2'd2));
    vecs.push_back(mk(0, 1, 0, 1, 20'h00008, 32'hA8A8A8A8, 1,  1, 1, 20'h00004, 32'hA4A4A4A4, 2'd1));
    vecs.push_back(mk(0, 1, 0, 0, 20'h00000, 32'h0,        1,  1, 0, 20'h00000, NOP,          2'd0));
    vecs.push_back(mk(0, 1, 0, 1, 20'h00008, 32'hA8A8A8A8, 0,  1, 1, 20'h00008, 32'hA8A8A8A8, 2'd1));
    vecs.push_back(mk(0, 1, 0, 1, 20'h0000C, 32'hACACACAC, 1,  1, 1, 20'h0000C, 32'hACACACAC, 2'd1));
    vecs.push_back(mk(0, 1, 0, 1, 20'h00018, 32'hB8B8B8B8, 0,  0, 1, 20'h0000C, 32'hACACACAC, 2'd2));
    vecs.push_back(mk(0, 1, 1, 1, 20'h00010, 32'hB0B0B0B0, 1,  1, 0, 20'h00000, NOP,          2'd0));
    vecs.push_back(mk(0, 1, 0, 0, 20'h00010, 32'hB0B0B0B0, 1,  1, 0, 20'h00000, NOP,          2'd0));
    vecs.push_back(mk(0, 1, 0, 1, 20'h00020, 32'hC0C0C0C0, 0,  1, 1, 20'h00020, 32'hC0C0C0C0, 2'd1));
    vecs.push_back(mk(0, 0, 0, 1, 20'h00024, 32'hC4C4C4C4, 1,  1, 1, 20'h00020, 32'hC0C0C0C0, 2'd1));
    vecs.push_back(mk(0, 0, 1, 1, 20'h00024, 32'hC4C4C4C4, 1,  1, 1, 20'h00020, 32'hC0C0C0C0, 2'd1));
    vecs.push_back(mk(0, 0, 0, 0, 20'h00024, 32'hC4C4C4C4, 1,  1, 1, 20'h00020, 32'hC0C0C0C0, 2'd1));
    vecs.push_back(mk(0, 1, 0, 1, 20'h00024, 32'hC4C4C4C4, 0,  0, 1, 20'h00020, 32'hC0C0C0C0, 2'd2));
    vecs.push_back(mk(1, 0, 0, 1, 20'h00028, 32'hC8C8C8C8, 1,  1, 0, 20'h00000, NOP,          2'd0));
    vecs.push_back(mk(0, 1, 0, 1, 20'h00028, 32'hC8C8C8C8, 0,  1, 1, 20'h00028, 32'hC8C8C8C8, 2'd1));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].flush, vecs[i].fv, vecs[i].pc, vecs[i].inst, vecs[i].dr);
      step();
      check_all($sformatf("vec%0d", i), vecs[i].e_ready, vecs[i].e_valid,
                vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_occ);
    end

    // Fill to two, then confirm ready and decode outputs ignore same-cycle decode/flush inputs.
    drive(1'b0, 1'b1, 1'b0, 1'b1, 20'h0002C, 32'hCCCCCCCC, 1'b0);
    step();
    check_all("fill", 1'b0, 1'b1, 20'h00028, 32'hC8C8C8C8, 2'd2);
    decode_ready_in = 1'b1; flush_in = 1'b1; #1;
    check("ready_indep_comb", {31'd0, fetch_ready_out}, 32'd0);
    check("valid_indep_comb", {31'd0, decode_valid_out}, 32'd1);
    drive(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    step();
    model.delete();
    check_model("rst_sync");

    for (int c = 0; c < 3000; c++) begin
      logic rst, en, flush, fv, dr;
      logic [PCW-1:0] pc;
      logic [IW-1:0]  inst;
      rst   = ($urandom_range(63) == 0);
      en    = ($urandom_range(7) != 0);
      flush = ($urandom_range(15) == 0);
      fv    = ($urandom_range(3) != 0);
      dr    = $urandom_range(1) == 1;
      pc    = PCW'($urandom);
      inst  = $urandom;
      drive(rst, en, flush, fv, pc, inst, dr);
      model_edge(rst, en, flush, fv, pc, inst, dr);
      step();
      check_model($sformatf("rnd%0d", c));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_fetch_decode_buffer

`default_nettype wire
